// File: rtl/orv32_decode_pipe.sv
// RV32 decode stage: one registered slot with a valid/ready handshake on both sides.
// FENCE (and SYSTEM, when SERIAL_SYS is set) blocks further input until the back end reports drain complete.
module orv32_decode_pipe #(
    parameter int XLEN       = 32,
    parameter int EN_M       = 1,
    parameter int EN_A       = 1,
    parameter int EN_F       = 0,
    parameter int EN_CSR     = 1,
    parameter int SERIAL_SYS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_inst_i,
    input  logic [XLEN-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [4:0]      out_opcode_o,
    output logic [2:0]      out_funct3_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [31:0]     out_imm_o,
    output logic [3:0]      out_cls_o,
    output logic            out_illegal_o,
    input  logic            serial_done_i
);
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_LOAD_FP  = 5'b00001;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_STORE_FP = 5'b01001;
    localparam logic [4:0] OPC_AMO      = 5'b01011;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_FMADD    = 5'b10000;
    localparam logic [4:0] OPC_FMSUB    = 5'b10001;
    localparam logic [4:0] OPC_FNMSUB   = 5'b10010;
    localparam logic [4:0] OPC_FNMADD   = 5'b10011;
    localparam logic [4:0] OPC_OP_FP    = 5'b10100;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [3:0] CLS_ALU    = 4'd0;
    localparam logic [3:0] CLS_BRANCH = 4'd1;
    localparam logic [3:0] CLS_JUMP   = 4'd2;
    localparam logic [3:0] CLS_LOAD   = 4'd3;
    localparam logic [3:0] CLS_STORE  = 4'd4;
    localparam logic [3:0] CLS_MULDIV = 4'd5;
    localparam logic [3:0] CLS_AMO    = 4'd6;
    localparam logic [3:0] CLS_FENCE  = 4'd7;
    localparam logic [3:0] CLS_SYSTEM = 4'd8;
    localparam logic [3:0] CLS_FP     = 4'd9;
    localparam logic [3:0] CLS_ILL    = 4'd15;

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  f5;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic        amo_f5_ok;
    logic        dec_ok;
    logic [3:0]  dec_cls;
    logic [31:0] dec_imm;
    logic        serialise;
    logic        accept;

    state_t      state_reg, state_next;
    logic        done_reg, done_next;
    logic        out_valid_reg;

    assign opc = in_inst_i[6:2];
    assign f3  = in_inst_i[14:12];
    assign f7  = in_inst_i[31:25];
    assign f5  = in_inst_i[31:27];

    assign imm_i = {{20{in_inst_i[31]}}, in_inst_i[31:20]};
    assign imm_s = {{20{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
    assign imm_b = {{19{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7], in_inst_i[30:25], in_inst_i[11:8], 1'b0};
    assign imm_u = {in_inst_i[31:12], 12'h000};
    assign imm_j = {{11{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12], in_inst_i[20], in_inst_i[30:21], 1'b0};
    assign imm_z = {27'd0, in_inst_i[19:15]};

    always_comb begin
        case (f5)
            5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
            5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100: amo_f5_ok = 1'b1;
            default:                                          amo_f5_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec_ok  = 1'b0;
        dec_cls = CLS_ALU;
        dec_imm = '0;
        if (in_inst_i[1:0] == 2'b11) begin
            case (opc)
                OPC_LOAD: begin
                    dec_ok  = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
                    dec_cls = CLS_LOAD;
                    dec_imm = imm_i;
                end
                OPC_STORE: begin
                    dec_ok  = (f3 <= 3'b010);
                    dec_cls = CLS_STORE;
                    dec_imm = imm_s;
                end
                OPC_BRANCH: begin
                    dec_ok  = (f3 != 3'b010) && (f3 != 3'b011);
                    dec_cls = CLS_BRANCH;
                    dec_imm = imm_b;
                end
                OPC_JALR: begin
                    dec_ok  = (f3 == 3'b000);
                    dec_cls = CLS_JUMP;
                    dec_imm = imm_i;
                end
                OPC_JAL: begin
                    dec_ok  = 1'b1;
                    dec_cls = CLS_JUMP;
                    dec_imm = imm_j;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_ok  = 1'b1;
                    dec_imm = imm_u;
                end
                OPC_OP_IMM: begin
                    // Shift-immediates reuse the upper immediate bits as funct7
                    if (f3 == 3'b001)
                        dec_ok = (f7 == 7'b0000000);
                    else if (f3 == 3'b101)
                        dec_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    else
                        dec_ok = 1'b1;
                    dec_imm = imm_i;
                end
                OPC_OP: begin
                    if (f7 == 7'b0000000) begin
                        dec_ok = 1'b1;
                    end else if (f7 == 7'b0100000) begin
                        dec_ok = (f3 == 3'b000) || (f3 == 3'b101);
                    end else if (f7 == 7'b0000001) begin
                        dec_ok  = (EN_M != 0);
                        dec_cls = CLS_MULDIV;
                    end
                end
                OPC_AMO: begin
                    dec_ok  = (EN_A != 0) && (f3 == 3'b010) && amo_f5_ok &&
                              !(f5 == 5'b00010 && in_inst_i[24:20] != 5'd0);
                    dec_cls = CLS_AMO;
                end
                OPC_MISC_MEM: begin
                    dec_ok  = 1'b1;
                    dec_cls = CLS_FENCE;
                end
                OPC_SYSTEM: begin
                    dec_ok  = (EN_CSR != 0) ? (f3 != 3'b100) : (f3 == 3'b000);
                    dec_cls = CLS_SYSTEM;
                    if (f3[2])
                        dec_imm = imm_z;
                end
                OPC_LOAD_FP, OPC_STORE_FP, OPC_FMADD, OPC_FMSUB,
                OPC_FNMSUB, OPC_FNMADD, OPC_OP_FP: begin
                    dec_ok  = (EN_F != 0);
                    dec_cls = CLS_FP;
                end
                default: dec_ok = 1'b0;
            endcase
        end
        if (!dec_ok) begin
            dec_cls = CLS_ILL;
            dec_imm = '0;
        end
    end

    assign serialise  = dec_ok && ((dec_cls == CLS_FENCE) ||
                                   ((SERIAL_SYS != 0) && (dec_cls == CLS_SYSTEM)));
    assign in_ready_o = (state_reg == ST_RUN) && !flush_i && (!out_valid_reg || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_next = state_reg;
        done_next  = done_reg;
        if (flush_i) begin
            state_next = ST_RUN;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (accept && serialise)
                        state_next = ST_HOLD;
                end
                ST_HOLD: begin
                    // Leave only once drained and the serialising instruction is gone from the slot
                    if ((done_reg || serial_done_i) && (!out_valid_reg || out_ready_i)) begin
                        state_next = ST_RUN;
                        done_next  = 1'b0;
                    end else if (serial_done_i) begin
                        done_next = 1'b1;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_pc_o      <= '0;
            out_opcode_o  <= '0;
            out_funct3_o  <= '0;
            out_rd_o      <= '0;
            out_rs1_o     <= '0;
            out_rs2_o     <= '0;
            out_imm_o     <= '0;
            out_cls_o     <= '0;
            out_illegal_o <= 1'b0;
        end else if (flush_i) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_pc_o      <= in_pc_i;
            out_opcode_o  <= opc;
            out_funct3_o  <= f3;
            out_rd_o      <= in_inst_i[11:7];
            out_rs1_o     <= in_inst_i[19:15];
            out_rs2_o     <= in_inst_i[24:20];
            out_imm_o     <= dec_imm;
            out_cls_o     <= dec_cls;
            out_illegal_o <= !dec_ok;
        end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_reg;
endmodule

// File: tb/tb_orv32_decode_pipe.sv
// Bench for orv32_decode_pipe: decode vector table on two configurations plus
// handshake, serialisation, flush and reset sequences.
module tb_orv32_decode_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic [31:0] in_inst_i;
    logic [31:0] in_pc_i;
    logic        out_ready_i;
    logic        serial_done_i;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [31:0] out_pc_a, out_imm_a;
    logic [4:0]  out_opcode_a, out_rd_a, out_rs1_a, out_rs2_a;
    logic [2:0]  out_funct3_a;
    logic [3:0]  out_cls_a;

    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [31:0] out_pc_b, out_imm_b;
    logic [4:0]  out_opcode_b, out_rd_b, out_rs1_b, out_rs2_b;
    logic [2:0]  out_funct3_b;
    logic [3:0]  out_cls_b;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;

    always #5 clk = ~clk;

    orv32_decode_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_a),
        .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_a), .out_opcode_o(out_opcode_a), .out_funct3_o(out_funct3_a),
        .out_rd_o(out_rd_a), .out_rs1_o(out_rs1_a), .out_rs2_o(out_rs2_a),
        .out_imm_o(out_imm_a), .out_cls_o(out_cls_a), .out_illegal_o(out_illegal_a),
        .serial_done_i(serial_done_i)
    );

    orv32_decode_pipe #(.EN_M(0), .EN_A(0)) dut_noext (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_b),
        .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_b), .out_opcode_o(out_opcode_b), .out_funct3_o(out_funct3_b),
        .out_rd_o(out_rd_b), .out_rs1_o(out_rs1_b), .out_rs2_o(out_rs2_b),
        .out_imm_o(out_imm_b), .out_cls_o(out_cls_b), .out_illegal_o(out_illegal_b),
        .serial_done_i(serial_done_i)
    );

    always @(posedge clk) begin
        if (out_valid_a && out_ready_i)
            hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  cls_a;
        logic [31:0] imm;
        logic [3:0]  cls_b;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_x1(input logic [11:0] k);
        return {k, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] exp_imm_b;

        vecs[0]  = '{32'h00500093, 4'd0,  32'h00000005, 4'd0};   // ADDI x1,x0,5
        vecs[1]  = '{32'hFE000EE3, 4'd1,  32'hFFFFFFFC, 4'd1};   // BEQ -4
        vecs[2]  = '{32'h02208033, 4'd5,  32'h00000000, 4'd15};  // MUL
        vecs[3]  = '{32'h100120AF, 4'd6,  32'h00000000, 4'd15};  // LR.W
        vecs[4]  = '{32'h101120AF, 4'd15, 32'h00000000, 4'd15};  // LR.W rs2=1
        vecs[5]  = '{32'h00500090, 4'd15, 32'h00000000, 4'd15};  // bad low bits
        vecs[6]  = '{32'h00002063, 4'd15, 32'h00000000, 4'd15};  // branch f3=010
        vecs[7]  = '{32'h0080A103, 4'd3,  32'h00000008, 4'd3};   // LW x2,8(x1)
        vecs[8]  = '{32'h0080B103, 4'd15, 32'h00000000, 4'd15};  // load f3=011
        vecs[9]  = '{32'hFE20AE23, 4'd4,  32'hFFFFFFFC, 4'd4};   // SW x2,-4(x1)
        vecs[10] = '{32'hFE20BE23, 4'd15, 32'h00000000, 4'd15};  // store f3=011
        vecs[11] = '{32'h123452B7, 4'd0,  32'h12345000, 4'd0};   // LUI
        vecs[12] = '{32'h008000EF, 4'd2,  32'h00000008, 4'd2};   // JAL +8
        vecs[13] = '{32'h000010E7, 4'd15, 32'h00000000, 4'd15};  // JALR f3=001
        vecs[14] = '{32'h402081B3, 4'd0,  32'h00000000, 4'd0};   // SUB
        vecs[15] = '{32'h402091B3, 4'd15, 32'h00000000, 4'd15};  // funct7 0100000 f3=001
        vecs[16] = '{32'h4030D093, 4'd0,  32'h00000403, 4'd0};   // SRAI
        vecs[17] = '{32'h40309093, 4'd15, 32'h00000000, 4'd15};  // SLLI bad funct7
        vecs[18] = '{32'h00004073, 4'd15, 32'h00000000, 4'd15};  // SYSTEM f3=100
        vecs[19] = '{32'h100130AF, 4'd15, 32'h00000000, 4'd15};  // AMO f3=011
        vecs[20] = '{32'h280120AF, 4'd15, 32'h00000000, 4'd15};  // AMO bad funct5
        vecs[21] = '{32'h00002007, 4'd15, 32'h00000000, 4'd15};  // FLW, F disabled
        vecs[22] = '{32'h003120AF, 4'd6,  32'h00000000, 4'd15};  // AMOADD.W
        vecs[23] = '{32'hFFF00093, 4'd0,  32'hFFFFFFFF, 4'd0};   // ADDI -1

        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_inst_i = '0;
        in_pc_i = '0; out_ready_i = 1'b1; serial_done_i = 1'b0;
        #2;
        check("reset out_valid", {31'd0, out_valid_a}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("reset in_ready", {31'd0, in_ready_a}, 32'd1);
        check("reset imm", out_imm_a, 32'd0);
        check("reset cls", {28'd0, out_cls_a}, 32'd0);
        check("reset pc", out_pc_a, 32'd0);

        // Decode table, one instruction per handshake
        for (int i = 0; i < NV; i++) begin
            w = vecs[i].inst;
            in_valid_i = 1'b1;
            in_inst_i  = w;
            in_pc_i    = 32'h1000 + 32'(i * 4);
            #1;
            check($sformatf("v%0d in_ready", i), {31'd0, in_ready_a}, 32'd1);
            step();
            in_valid_i = 1'b0;
            exp_imm_b = (vecs[i].cls_b == 4'd15) ? 32'd0 : vecs[i].imm;
            check($sformatf("v%0d valid", i), {31'd0, out_valid_a}, 32'd1);
            check($sformatf("v%0d cls", i), {28'd0, out_cls_a}, {28'd0, vecs[i].cls_a});
            check($sformatf("v%0d imm", i), out_imm_a, vecs[i].imm);
            check($sformatf("v%0d illegal", i), {31'd0, out_illegal_a}, {31'd0, vecs[i].cls_a == 4'd15});
            check($sformatf("v%0d rd", i), {27'd0, out_rd_a}, {27'd0, w[11:7]});
            check($sformatf("v%0d rs1", i), {27'd0, out_rs1_a}, {27'd0, w[19:15]});
            check($sformatf("v%0d rs2", i), {27'd0, out_rs2_a}, {27'd0, w[24:20]});
            check($sformatf("v%0d funct3", i), {29'd0, out_funct3_a}, {29'd0, w[14:12]});
            check($sformatf("v%0d opcode", i), {27'd0, out_opcode_a}, {27'd0, w[6:2]});
            check($sformatf("v%0d pc", i), out_pc_a, 32'h1000 + 32'(i * 4));
            check($sformatf("v%0d noext cls", i), {28'd0, out_cls_b}, {28'd0, vecs[i].cls_b});
            check($sformatf("v%0d noext imm", i), out_imm_b, exp_imm_b);
            check($sformatf("v%0d noext illegal", i), {31'd0, out_illegal_b}, {31'd0, vecs[i].cls_b == 4'd15});
            step();
            check($sformatf("v%0d drained", i), {31'd0, out_valid_a}, 32'd0);
        end

        // Four ADDIs with a three-cycle output stall in the middle
        hs_cnt = 0;
        in_valid_i = 1'b1; in_inst_i = addi_x1(12'd1);
        step();
        check("stream out1", out_imm_a, 32'd1);
        in_inst_i = addi_x1(12'd2);
        #1;
        check("stream ready2", {31'd0, in_ready_a}, 32'd1);
        step();
        check("stream out2", out_imm_a, 32'd2);
        out_ready_i = 1'b0;
        in_inst_i = addi_x1(12'd3);
        #1;
        check("stall in_ready", {31'd0, in_ready_a}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("stall%0d valid", k), {31'd0, out_valid_a}, 32'd1);
            check($sformatf("stall%0d imm", k), out_imm_a, 32'd2);
            check($sformatf("stall%0d in_ready", k), {31'd0, in_ready_a}, 32'd0);
        end
        step();
        check("stall end imm", out_imm_a, 32'd2);
        out_ready_i = 1'b1;
        #1;
        check("resume in_ready", {31'd0, in_ready_a}, 32'd1);
        step();
        check("stream out3", out_imm_a, 32'd3);
        in_inst_i = addi_x1(12'd4);
        step();
        check("stream out4", out_imm_a, 32'd4);
        check("stream valid4", {31'd0, out_valid_a}, 32'd1);
        in_valid_i = 1'b0;
        step();
        check("stream drained", {31'd0, out_valid_a}, 32'd0);
        check("stream handshakes", 32'(hs_cnt), 32'd4);

        // FENCE then ADDI; drain pulse arrives while FENCE still waits in the slot
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_inst_i = 32'h0FF0000F;
        step();
        check("fence cls", {28'd0, out_cls_a}, 32'd7);
        in_inst_i = addi_x1(12'd5);
        #1;
        check("fence hold ready", {31'd0, in_ready_a}, 32'd0);
        step();
        check("fence hold ready2", {31'd0, in_ready_a}, 32'd0);
        serial_done_i = 1'b1;
        step();
        serial_done_i = 1'b0;
        #1;
        check("fence done unconsumed ready", {31'd0, in_ready_a}, 32'd0);
        check("fence still held", {28'd0, out_cls_a}, 32'd7);
        step();
        out_ready_i = 1'b1;
        #1;
        check("fence handshake cycle ready", {31'd0, in_ready_a}, 32'd0);
        step();
        check("fence consumed", {31'd0, out_valid_a}, 32'd0);
        check("after fence ready", {31'd0, in_ready_a}, 32'd1);
        step();
        check("after fence addi", out_imm_a, 32'd5);
        check("after fence valid", {31'd0, out_valid_a}, 32'd1);
        in_valid_i = 1'b0;
        step();

        // CSRRWI serialises and carries zimm
        in_valid_i = 1'b1; in_inst_i = 32'h3002D0F3;
        step();
        in_valid_i = 1'b0;
        check("csrrwi cls", {28'd0, out_cls_a}, 32'd8);
        check("csrrwi zimm", out_imm_a, 32'd5);
        #1;
        check("csrrwi hold ready", {31'd0, in_ready_a}, 32'd0);
        step();
        check("csrrwi gone", {31'd0, out_valid_a}, 32'd0);
        check("csrrwi wait ready", {31'd0, in_ready_a}, 32'd0);
        serial_done_i = 1'b1;
        step();
        serial_done_i = 1'b0;
        #1;
        check("csrrwi released", {31'd0, in_ready_a}, 32'd1);

        // Flush while holding a FENCE
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_inst_i = 32'h0FF0000F;
        step();
        in_valid_i = 1'b0;
        check("flush pre valid", {31'd0, out_valid_a}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush cycle ready", {31'd0, in_ready_a}, 32'd0);
        step();
        flush_i = 1'b0;
        check("flush out_valid", {31'd0, out_valid_a}, 32'd0);
        #1;
        check("flush in_ready", {31'd0, in_ready_a}, 32'd1);

        // Asynchronous reset with a valid output
        in_valid_i = 1'b1; in_inst_i = addi_x1(12'd7); in_pc_i = 32'h2000;
        step();
        in_valid_i = 1'b0;
        check("prereset valid", {31'd0, out_valid_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset valid", {31'd0, out_valid_a}, 32'd0);
        check("async reset imm", out_imm_a, 32'd0);
        check("async reset rd", {27'd0, out_rd_a}, 32'd0);
        check("async reset pc", out_pc_a, 32'd0);
        step();
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/orv32_decode_pipe.md
Name: orv32_decode_pipe

Overview:
Parametrised, registered RV32 decode stage that replaces the flat opcode constant tables with a handshaked pipeline stage. It accepts raw 32-bit instructions from fetch and checks each one against the enabled extension set (M, A, F, Zicsr). It emits decoded fields, a sign-extended immediate, an instruction class and an illegal flag to the issue stage. It also serialises FENCE/SYSTEM instructions until the back end signals drain complete.

Parameters:
XLEN, 32, PC width carried alongside the instruction.
EN_M, 1, accept RV32M encodings (OP with funct7=0000001).
EN_A, 1, accept AMO opcode 01011.
EN_F, 0, accept LOAD_FP/STORE_FP/FMADD..FNMADD/OP_FP opcodes (class FP only, no field checks).
EN_CSR, 1, accept CSRRW..CSRRCI; when 0, SYSTEM only permits funct3=000.
SERIAL_SYS, 1, SYSTEM instructions serialise in addition to FENCE.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  kill stage contents and serialisation wait
in_valid_i  in  1  fetch valid
in_ready_o  out  1  stage can accept
in_inst_i  in  32  raw instruction
in_pc_i  in  XLEN  instruction PC
out_valid_o  out  1  decoded instruction valid
out_ready_i  in  1  issue accepts
out_pc_o  out  XLEN  PC
out_opcode_o  out  5  inst[6:2]
out_funct3_o  out  3  inst[14:12]
out_rd_o / out_rs1_o / out_rs2_o  out  5 each  register indices
out_imm_o  out  32  immediate
out_cls_o  out  4  class: 0 ALU, 1 BRANCH, 2 JUMP, 3 LOAD, 4 STORE, 5 MULDIV, 6 AMO, 7 FENCE, 8 SYSTEM, 9 FP, 15 ILLEGAL
out_illegal_o  out  1  illegal instruction
serial_done_i  in  1  back end drained (pulse)

Behaviour:
- Reset (async, rst_n=0): out_valid_o=0, all data outputs 0, FSM=RUN, done flag=0.
- Single register stage; latency 1 cycle from input handshake to out_valid_o.
- in_ready_o = (state==RUN) && !flush_i && (!out_valid_o || out_ready_i). Back-to-back throughput is 1/cycle.
- Output fields hold stable while out_valid_o && !out_ready_i.
- Immediates by format:
  - I: LOAD, OP_IMM, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC, with low 12 bits zero.
  - J: JAL.
  - All are sign-extended from inst[31].
  - CSR*I: zimm = zero-extended inst[19:15].
  - Others: 0.
- Illegal conditions (cls=15, illegal=1, imm=0, indices still passed through):
  - inst[1:0]!=11.
  - Unlisted opcode.
  - Disabled extension.
  - BRANCH funct3 010/011.
  - LOAD funct3 011/110/111.
  - STORE funct3 >010.
  - JALR funct3!=000.
  - OP funct7 not 0000000, 0100000 (funct3 000/101 only) or 0000001 (EN_M).
  - SLLI funct7!=0.
  - SRLI/SRAI funct7 not 0000000/0100000.
  - SYSTEM funct3=100.
  - AMO funct3!=010 or funct5 not in {LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU}.
  - LR with rs2!=0.
- Serialisation FSM:
  - States: RUN, HOLD.
  - RUN->HOLD when a FENCE, or a SYSTEM instruction with SERIAL_SYS=1, is accepted on the input (illegal instructions never serialise).
  - In HOLD, in_ready_o=0.
  - serial_done_i in HOLD sets a sticky done flag.
  - HOLD->RUN in the first cycle where (done flag || serial_done_i) && the serialising instruction has left the output register (out_valid_o=0, or a handshake this cycle). Done flag clears on exit.
  - serial_done_i in RUN is ignored.
- flush_i:
  - Next cycle: out_valid_o=0, FSM=RUN, done flag=0.
  - No input is accepted in the flush cycle.
  - Flush has priority over any simultaneous handshake or serial_done_i.
- Reset mid-HOLD returns to RUN immediately.

Test Plan:
1. 0x00500093 (ADDI x1,x0,5) -> next cycle out_valid=1, cls=0, rd=1, rs1=0, imm=0x00000005, illegal=0.
2. 0xFE000EE3 (BEQ x0,x0,-4) -> cls=1, imm=0xFFFFFFFC. 0x02208033 (MUL) with EN_M=0 -> illegal=1, cls=15. Same instruction with EN_M=1 -> cls=5.
3. Stream 4 ADDIs with out_ready_i low for 3 cycles mid-stream -> no loss or duplication, output held stable, in_ready_o low while stalled.
4. 0x0FF0000F (FENCE) followed by ADDI -> in_ready_o=0 until serial_done_i. Pulse serial_done_i while the FENCE is still unconsumed -> ADDI is accepted only after the FENCE handshake.
5. 0x100120AF (LR.W x1,(x2)) with EN_A=1 -> cls=6. Same with rs2=1 -> illegal. EN_A=0 -> illegal.
6. Assert flush_i in HOLD with a valid output -> out_valid=0 and in_ready=1 the cycle after. Assert rst_n low mid-stream -> all outputs 0 asynchronously.
